// File: rtl/liteic_pkg.sv
// rtl/liteic_pkg.sv - shared types and helpers for the AXI-lite interconnect
//
// Purpose:
//   Response-code enumeration and the binary-to-one-hot master select decode
//   used by the response routers and any other block that must turn a binary
//   master index into a slot select.
//
// Contents:
//   resp_t           AXI-lite response code (OKAY/EXOKAY/SLVERR/DECERR)
//   MAX_SLOTS        largest master slot count the interconnect supports
//   MAX_ID_W         width of a binary index able to address MAX_SLOTS
//   id_to_onehot()   binary index -> one-hot select, zero when index >= n
package liteic_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int unsigned MAX_SLOTS = 32;
    localparam int unsigned MAX_ID_W  = 5;

    // Callers zero-extend their index to MAX_ID_W bits. An index that names a
    // slot beyond the populated range decodes to all zeros so that the caller
    // can detect the bad ID by OR-reducing the result.
    function automatic logic [MAX_SLOTS-1:0] id_to_onehot(
        input logic [MAX_ID_W-1:0] id,
        input int unsigned         n
    );
        logic [MAX_SLOTS-1:0] sel;
        sel = '0;
        if (32'(id) < n) begin
            sel[id] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/liteic_id_fifo.sv
// rtl/liteic_id_fifo.sv - in-order ID FIFO for outstanding AXI-lite requests
//
// Purpose:
//   Small synchronous FIFO holding the binary master index of every request
//   that has been accepted downstream and still awaits its response.
//
// Parameters:
//   WIDTH   entry width (binary master index width)
//   DEPTH   number of entries, power of two, >= 2
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (flushes pointers and count)
//   push    write din at the tail; ignored while full
//   pop     discard the head entry; ignored while empty
//   din     entry to write
//   dout    current head entry (valid while !empty)
//   full    count == DEPTH
//   empty   count == 0
//   count   current occupancy
module liteic_id_fifo #(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_do_push;
    logic             w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A push is refused while full even if a pop happens in the same cycle,
    // so req_ready_o never depends on the response side combinationally.
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/liteic_resp_router.sv
// rtl/liteic_resp_router.sv - AXI-lite response router (one slave port, one channel)
//
// Purpose:
//   Records the master index of each request accepted by the slave in an
//   in-order ID FIFO, then steers every slave response to the master named at
//   the FIFO head through a single registered output buffer (obuf).
//   Responses whose recorded ID does not name a populated slot are consumed
//   and flagged with a one-cycle err_id_o pulse.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   req_valid_i     request accepted downstream; push req_id_i
//   req_id_i        binary index of the granted master
//   req_ready_o     ID FIFO not full
//   s_valid_i       slave response valid
//   s_data_i        slave response data
//   s_resp_i        slave response code
//   s_ready_o       slave response accepted this cycle
//   m_valid_o       one-hot response valid per master slot
//   m_data_o        registered response data, broadcast to all slots
//   m_resp_o        registered response code, broadcast to all slots
//   m_ready_i       per-slot ready
//   err_id_o        pulse: a response was dropped for an out-of-range ID
//   outstanding_o   current ID FIFO occupancy
module liteic_resp_router
    import liteic_pkg::*;
#(
    parameter int unsigned IC_NUM_MASTER_SLOTS = 20,
    parameter int unsigned ID_WIDTH            = $clog2(IC_NUM_MASTER_SLOTS),
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned DEPTH               = 4,
    localparam int unsigned N     = IC_NUM_MASTER_SLOTS,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid_i,
    input  logic [ID_WIDTH-1:0]   req_id_i,
    output logic                  req_ready_o,

    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic [1:0]            s_resp_i,
    output logic                  s_ready_o,

    output logic [N-1:0]          m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            m_resp_o,
    input  logic [N-1:0]          m_ready_i,

    output logic                  err_id_o,
    output logic [CNT_W-1:0]      outstanding_o
);

    // ID FIFO
    logic [ID_WIDTH-1:0]  w_head_id;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_accept;

    liteic_id_fifo #(
        .WIDTH (ID_WIDTH),
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid_i),
        .pop   (w_accept),
        .din   (req_id_i),
        .dout  (w_head_id),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (outstanding_o)
    );

    assign req_ready_o = ~w_fifo_full;

    // Head decode. The full-width select is OR-reduced to find the bad-ID
    // case; bits at or above N are always zero by construction.
    logic [MAX_SLOTS-1:0] w_sel_full;
    logic [N-1:0]         w_sel;
    logic                 w_sel_hit;

    assign w_sel_full = id_to_onehot(MAX_ID_W'(w_head_id), N);
    assign w_sel      = w_sel_full[N-1:0];
    assign w_sel_hit  = |w_sel_full;

    // Output buffer
    logic                  r_obuf_valid;
    logic [N-1:0]          r_obuf_sel;
    logic [DATA_WIDTH-1:0] r_obuf_data;
    logic [1:0]            r_obuf_resp;
    logic                  r_err_id;

    logic                  w_drain;
    logic                  w_obuf_free;

    assign m_valid_o = r_obuf_valid ? r_obuf_sel : '0;
    assign m_data_o  = r_obuf_data;
    assign m_resp_o  = r_obuf_resp;
    assign err_id_o  = r_err_id;

    // The drain term lets a waiting response enter obuf in the same cycle the
    // previous one leaves, giving one response per cycle; it is the only
    // combinational path from m_ready_i to s_ready_o.
    assign w_drain     = |(m_valid_o & m_ready_i);
    assign w_obuf_free = ~r_obuf_valid | w_drain;

    // No FIFO bypass: an ID pushed this cycle cannot match a response until
    // the next, so an empty FIFO stalls the slave rather than dropping data.
    assign s_ready_o = ~w_fifo_empty & w_obuf_free;
    assign w_accept  = s_valid_i & s_ready_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_obuf_valid <= 1'b0;
            r_obuf_sel   <= '0;
            r_obuf_data  <= '0;
            r_obuf_resp  <= OKAY;
            r_err_id     <= 1'b0;
        end else begin
            r_err_id <= w_accept & ~w_sel_hit;
            if (w_accept && w_sel_hit) begin
                r_obuf_valid <= 1'b1;
                r_obuf_sel   <= w_sel;
                r_obuf_data  <= s_data_i;
                r_obuf_resp  <= s_resp_i;
            end else if (w_drain) begin
                // Data and resp hold their last value while nothing is valid.
                r_obuf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_liteic_resp_router.sv
// tb/tb_liteic_resp_router.sv - directed self-checking bench for liteic_resp_router
module tb_liteic_resp_router;

    localparam int unsigned N   = 20;
    localparam int unsigned IDW = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned DEP = 4;
    localparam int unsigned CW  = 3;

    logic           clk;
    logic           rst_n;
    logic           req_valid_i;
    logic [IDW-1:0] req_id_i;
    logic           req_ready_o;
    logic           s_valid_i;
    logic [DW-1:0]  s_data_i;
    logic [1:0]     s_resp_i;
    logic           s_ready_o;
    logic [N-1:0]   m_valid_o;
    logic [DW-1:0]  m_data_o;
    logic [1:0]     m_resp_o;
    logic [N-1:0]   m_ready_i;
    logic           err_id_o;
    logic [CW-1:0]  outstanding_o;

    int n_chk;
    int n_err;

    liteic_resp_router #(
        .IC_NUM_MASTER_SLOTS (N),
        .ID_WIDTH            (IDW),
        .DATA_WIDTH          (DW),
        .DEPTH               (DEP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid_i   (req_valid_i),
        .req_id_i      (req_id_i),
        .req_ready_o   (req_ready_o),
        .s_valid_i     (s_valid_i),
        .s_data_i      (s_data_i),
        .s_resp_i      (s_resp_i),
        .s_ready_o     (s_ready_o),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_resp_o      (m_resp_o),
        .m_ready_i     (m_ready_i),
        .err_id_o      (err_id_o),
        .outstanding_o (outstanding_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int i);
        logic [63:0] v;
        v = 64'd1 << i;
        return v;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id);
        req_valid_i = 1'b1;
        req_id_i    = IDW'(id);
        step();
        req_valid_i = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_id_i    = '0;
        s_valid_i   = 1'b0;
        s_data_i    = '0;
        s_resp_i    = 2'b00;
        m_ready_i   = '1;

        // Reset values
        #3;
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_s_ready",   64'(s_ready_o),   64'd0);
        chk("rst_m_valid",   64'(m_valid_o),   64'd0);
        chk("rst_m_data",    64'(m_data_o),    64'd0);
        chk("rst_m_resp",    64'(m_resp_o),    64'd0);
        chk("rst_err",       64'(err_id_o),    64'd0);
        chk("rst_outst",     64'(outstanding_o), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Basic routing: IDs 3, 0, 19
        push(3);
        push(0);
        push(19);
        chk("basic_outst3", 64'(outstanding_o), 64'd3);
        s_valid_i = 1'b1;
        s_data_i  = 32'hA;
        s_resp_i  = 2'b00;
        #1;
        chk("basic_s_ready", 64'(s_ready_o), 64'd1);
        step();
        chk("basic_v0", 64'(m_valid_o), oh(3));
        chk("basic_d0", 64'(m_data_o), 64'hA);
        s_data_i = 32'hB;
        step();
        chk("basic_v1", 64'(m_valid_o), oh(0));
        chk("basic_d1", 64'(m_data_o), 64'hB);
        s_data_i = 32'hC;
        step();
        s_valid_i = 1'b0;
        chk("basic_v2", 64'(m_valid_o), oh(19));
        chk("basic_d2", 64'(m_data_o), 64'hC);
        chk("basic_outst0", 64'(outstanding_o), 64'd0);
        step();
        chk("basic_idle_v", 64'(m_valid_o), 64'd0);
        chk("basic_hold_d", 64'(m_data_o), 64'hC);

        // Backpressure on slot 5 with two queued responses
        push(5);
        push(5);
        m_ready_i    = '1;
        m_ready_i[5] = 1'b0;
        s_valid_i    = 1'b1;
        s_data_i     = 32'h11;
        step();
        chk("bp_first_v", 64'(m_valid_o), oh(5));
        s_data_i = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_s_ready_low", 64'(s_ready_o), 64'd0);
            chk("bp_hold_v", 64'(m_valid_o), oh(5));
            chk("bp_hold_d", 64'(m_data_o), 64'h11);
            step();
        end
        m_ready_i[5] = 1'b1;
        #1;
        chk("bp_s_ready_hi", 64'(s_ready_o), 64'd1);
        step();
        s_valid_i = 1'b0;
        chk("bp_second_v", 64'(m_valid_o), oh(5));
        chk("bp_second_d", 64'(m_data_o), 64'h22);
        chk("bp_outst0", 64'(outstanding_o), 64'd0);
        step();
        chk("bp_idle_v", 64'(m_valid_o), 64'd0);

        // Full FIFO
        push(1);
        push(2);
        push(3);
        push(4);
        chk("full_outst4", 64'(outstanding_o), 64'd4);
        chk("full_req_ready", 64'(req_ready_o), 64'd0);
        req_valid_i = 1'b1;
        req_id_i    = IDW'(6);
        step();
        chk("full_5th_refused", 64'(outstanding_o), 64'd4);
        s_valid_i = 1'b1;
        s_data_i  = 32'h33;
        step();
        req_valid_i = 1'b0;
        chk("full_pushpop_outst", 64'(outstanding_o), 64'd3);
        chk("full_v1", 64'(m_valid_o), oh(1));
        s_data_i = 32'h44;
        step();
        chk("full_v2", 64'(m_valid_o), oh(2));
        s_data_i = 32'h55;
        step();
        chk("full_v3", 64'(m_valid_o), oh(3));
        s_data_i = 32'h66;
        step();
        s_valid_i = 1'b0;
        chk("full_v4", 64'(m_valid_o), oh(4));
        chk("full_d4", 64'(m_data_o), 64'h66);
        chk("full_outst0", 64'(outstanding_o), 64'd0);
        step();

        // Empty stall
        s_valid_i = 1'b1;
        s_data_i  = 32'h77;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("empty_s_ready", 64'(s_ready_o), 64'd0);
            chk("empty_m_valid", 64'(m_valid_o), 64'd0);
            step();
        end
        req_valid_i = 1'b1;
        req_id_i    = IDW'(7);
        #1;
        chk("empty_no_bypass", 64'(s_ready_o), 64'd0);
        step();
        req_valid_i = 1'b0;
        #1;
        chk("empty_s_ready_next", 64'(s_ready_o), 64'd1);
        step();
        s_valid_i = 1'b0;
        chk("empty_v7", 64'(m_valid_o), oh(7));
        chk("empty_d7", 64'(m_data_o), 64'h77);
        step();

        // Bad ID 25
        push(25);
        s_valid_i = 1'b1;
        s_data_i  = 32'h88;
        s_resp_i  = 2'b10;
        #1;
        chk("bad_s_ready", 64'(s_ready_o), 64'd1);
        step();
        s_valid_i = 1'b0;
        chk("bad_err_pulse", 64'(err_id_o), 64'd1);
        chk("bad_no_valid", 64'(m_valid_o), 64'd0);
        chk("bad_consumed", 64'(outstanding_o), 64'd0);
        chk("bad_data_held", 64'(m_data_o), 64'h77);
        step();
        chk("bad_err_clear", 64'(err_id_o), 64'd0);
        push(2);
        s_valid_i = 1'b1;
        s_data_i  = 32'h99;
        s_resp_i  = 2'b01;
        step();
        s_valid_i = 1'b0;
        chk("bad_next_v2", 64'(m_valid_o), oh(2));
        chk("bad_next_resp", 64'(m_resp_o), 64'd1);
        chk("bad_next_err", 64'(err_id_o), 64'd0);
        step();

        // Async reset with 2 outstanding and obuf valid
        push(9);
        push(10);
        push(11);
        m_ready_i = '0;
        s_valid_i = 1'b1;
        s_data_i  = 32'hDD;
        s_resp_i  = 2'b11;
        step();
        s_valid_i = 1'b0;
        chk("ar_pre_v", 64'(m_valid_o), oh(9));
        chk("ar_pre_outst", 64'(outstanding_o), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_m_valid", 64'(m_valid_o), 64'd0);
        chk("ar_m_data", 64'(m_data_o), 64'd0);
        chk("ar_m_resp", 64'(m_resp_o), 64'd0);
        chk("ar_outst", 64'(outstanding_o), 64'd0);
        chk("ar_req_ready", 64'(req_ready_o), 64'd1);
        chk("ar_s_ready", 64'(s_ready_o), 64'd0);
        chk("ar_err", 64'(err_id_o), 64'd0);
        step();
        rst_n     = 1'b1;
        m_ready_i = '1;
        step();
        push(1);
        s_valid_i = 1'b1;
        s_data_i  = 32'hAB;
        s_resp_i  = 2'b00;
        step();
        s_valid_i = 1'b0;
        chk("ar_after_v1", 64'(m_valid_o), oh(1));
        chk("ar_after_d", 64'(m_data_o), 64'hAB);
        chk("ar_after_outst", 64'(outstanding_o), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/liteic_resp_router.md
# liteic_resp_router

Response-path router for the AXI-lite interconnect: the return-direction counterpart of master arbitration. When a request from a master slot is accepted by a slave, its binary master index is pushed into an in-order ID FIFO. Each slave response is then decoded from that index to a one-hot master select and delivered through a registered output stage to exactly one master slot. There is one instance per slave port and per channel (B or R).

## Interface
- IC_NUM_MASTER_SLOTS, 20, number of master slots N (2..32)
- ID_WIDTH, $clog2(IC_NUM_MASTER_SLOTS), width of the binary master index
- DATA_WIDTH, 32, response payload width (1 for the B channel, where data is ignored)
- DEPTH, 4, maximum outstanding transactions tracked (power of two, ≥2)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  granted request accepted downstream; push req_id_i
- req_id_i  in  ID_WIDTH  binary index of the granted master
- req_ready_o  out  1  ID FIFO can accept a push (not full)
- s_valid_i  in  1  slave response valid
- s_data_i  in  DATA_WIDTH  slave response data
- s_resp_i  in  2  slave response code
- s_ready_o  out  1  response accepted this cycle
- m_valid_o  out  N  one-hot response valid per master slot
- m_data_o  out  DATA_WIDTH  registered data, broadcast to all slots
- m_resp_o  out  2  registered response code, broadcast
- m_ready_i  in  N  per-slot ready
- err_id_o  out  1  single-cycle pulse: a response was dropped because its ID was ≥ N
- outstanding_o  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Push: req_valid_i & req_ready_o writes req_id_i at the tail. req_ready_o = (count != DEPTH). A push is never accepted while full, even if a pop happens in the same cycle.
- Head decode: sel[i] = (head_id == i) for i < N. If head_id ≥ N, sel is all zeros.
- Output register (obuf) has a valid bit, a one-hot select, data and resp. Its entry drains when (m_valid_o & m_ready_i) != 0.
- obuf_free = !obuf_valid | drain.
- s_ready_o = (count != 0) & obuf_free.
- Accept (s_valid_i & s_ready_o):
  - Pops the FIFO head.
  - If sel != 0: loads obuf with sel, s_data_i and s_resp_i.
  - If sel == 0 (bad ID): obuf is not loaded, the response is consumed, and err_id_o pulses the following cycle.
- When the FIFO is empty, s_ready_o is held low. The response stalls and is not dropped.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- m_valid_o is either all zeros or exactly one-hot. m_data_o and m_resp_o hold their value while m_valid_o is zero.
- Reset mid-operation: the FIFO is flushed and the in-flight obuf entry is discarded. No recovery of outstanding IDs.

## Timing
- Reset values: req_ready_o=1, s_ready_o=0, m_valid_o=0, m_data_o=0, m_resp_o=0 (OKAY), err_id_o=0, outstanding_o=0. Pointers and count are 0.
- Latency from response accept to m_valid_o is 1 cycle.
- Throughput is 1 response per cycle while the target master holds ready: s_ready_o depends combinationally on m_ready_i through drain.
- Push-to-visible: an ID pushed in cycle t can be matched by a response in cycle t+1 at the earliest. There is no FIFO bypass, so s_ready_o stays 0 in cycle t if the FIFO was empty.
- Ordering is strictly in order (AXI-lite); responses leave in push order.
- Combinational paths: m_ready_i → s_ready_o only. req_ready_o is purely registered-state based.

## Structure
- liteic_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - A function for the binary-to-one-hot decode with range check, shared with other interconnect blocks.
- Sub-module liteic_id_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count; async active-low reset.
- Top level contains the decode, the obuf stage and the error pulse.

## Test plan
- Basic routing: push IDs 3, 0, 19; return three OKAY responses with data 0xA, 0xB, 0xC, all m_ready_i=1.
  - m_valid_o = bit3, then bit0, then bit19 on consecutive cycles.
  - Data values are in order; outstanding_o goes 3→0.
- Backpressure: push ID 5, m_ready_i[5]=0 for 4 cycles, with two queued responses.
  - m_valid_o[5] is held and m_data_o is stable.
  - s_ready_o=0 until m_ready_i[5]=1, then one transfer per cycle.
- Full FIFO: push 4 IDs with no responses.
  - req_ready_o=0 and outstanding_o=4.
  - A 5th push is not taken. A same-cycle push and pop while full leaves count at 3 after the pop.
- Empty stall: s_valid_i=1 with no pushes for 3 cycles → s_ready_o=0 and m_valid_o=0. Push ID 7 → response accepted the next cycle and routed to bit 7.
- Bad ID: push ID 25 (N=20), then a SLVERR response.
  - The response is consumed, m_valid_o stays 0, and err_id_o=1 for exactly one cycle.
  - The following pushed ID 2 is routed correctly.
- Async reset: assert rst_n low between clock edges with 2 outstanding IDs and obuf valid.
  - All outputs take their reset values immediately.
  - After release, a push of ID 1 plus a response routes to bit 1.
